cdec_bus_ctrl: RTL and testbench

//  Parametrised bus-interface unit between the CDEC core (control word + datapath) and memory/IO.

---
 rtl/cdec_bus_ctrl_pkg.sv | 24 ++
 rtl/cdec_bus_ctrl_tmo.sv | 38 +++
 rtl/cdec_bus_ctrl.sv | 161 ++++++++++++++++
 tb/tb_cdec_bus_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cdec_bus_ctrl_pkg.sv
// Shared encodings for the CDEC bus-interface unit: core access codes and controller states.
package cdec_bus_ctrl_pkg;

    typedef enum logic [1:0] {
        MM_IDLE = 2'b00,
        MM_WR   = 2'b01,
        MM_RD   = 2'b10,
        MM_RSVD = 2'b11
    } mmrw_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MEM  = 3'd1,
        ST_IO   = 3'd2,
        ST_DBG  = 3'd3,
        ST_DONE = 3'd4
    } state_e;

    // Only read and write start an access; the reserved code behaves as idle.
    function automatic logic is_req(input logic [1:0] mmrw);
        return (mmrw == MM_WR) || (mmrw == MM_RD);
    endfunction

endpackage

// File: rtl/cdec_bus_ctrl_tmo.sv
// Bus wait-state counter: cleared outside a strobe, counts unanswered strobe cycles, flags the last one.
module cdec_bus_ctrl_tmo #(
    parameter int unsigned TMO = 15
) (
    input  logic clock_i,
    input  logic reset_i,
    input  logic clr_i,
    input  logic inc_i,
    output logic tc_c_o
);

    localparam int unsigned CW = $clog2(TMO + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Saturates at TMO so a stuck strobe can never wrap the count.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != CW'(TMO))) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // High in the TMO-th strobe cycle, so the strobe is held exactly TMO cycles.
    assign tc_c_o = (cnt_q == CW'(TMO - 1));

endmodule

// File: rtl/cdec_bus_ctrl.sv
// CDEC bus-interface unit: handshaked memory access with wait states and timeout,
// a memory-mapped IO register and a post-halt debug readback port.
module cdec_bus_ctrl
    import cdec_bus_ctrl_pkg::*;
#(
    parameter int unsigned   DW      = 8,
    parameter int unsigned   AW      = 8,
    parameter logic [AW-1:0] IO_ADDR = AW'(8'hFF),
    parameter int unsigned   TMO     = 15
) (
    input  logic          clock_i,
    input  logic          reset_i,
    input  logic [1:0]    cpu_mmrw_i,
    input  logic [AW-1:0] cpu_adrs_i,
    input  logic [DW-1:0] cpu_wdata_i,
    output logic [DW-1:0] cpu_rdata_o,
    output logic          cpu_stall_c_o,
    output logic          cpu_done_o,
    output logic          bus_err_o,
    output logic [AW-1:0] mem_adrs_o,
    output logic [DW-1:0] mem_wdata_o,
    output logic          mem_wr_en_o,
    output logic          mem_rd_en_o,
    input  logic [DW-1:0] mem_rdata_i,
    input  logic          mem_ready_i,
    input  logic [DW-1:0] io_in_i,
    output logic [DW-1:0] io_out_o,
    input  logic          endseq_i,
    input  logic [AW-1:0] resad_i,
    output logic [DW-1:0] resdt_o
);

    state_e        state_q;
    logic          wr_q;
    logic [DW-1:0] cpu_rdata_q;
    logic          cpu_done_q;
    logic          bus_err_q;
    logic [AW-1:0] mem_adrs_q;
    logic [DW-1:0] mem_wdata_q;
    logic          mem_wr_en_q;
    logic          mem_rd_en_q;
    logic [DW-1:0] io_out_q;
    logic [DW-1:0] resdt_q;

    logic req_c;
    logic on_bus_c;
    logic tc_c;

    assign req_c    = is_req(cpu_mmrw_i);
    assign on_bus_c = (state_q == ST_MEM) || (state_q == ST_DBG);

    cdec_bus_ctrl_tmo #(
        .TMO (TMO)
    ) u_tmo (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .clr_i   (!on_bus_c),
        .inc_i   (on_bus_c && !mem_ready_i),
        .tc_c_o  (tc_c)
    );

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= ST_IDLE;
            wr_q        <= 1'b0;
            cpu_rdata_q <= '0;
            cpu_done_q  <= 1'b0;
            bus_err_q   <= 1'b0;
            mem_adrs_q  <= '0;
            mem_wdata_q <= '0;
            mem_wr_en_q <= 1'b0;
            mem_rd_en_q <= 1'b0;
            io_out_q    <= '0;
            resdt_q     <= '0;
        end else begin
            cpu_done_q <= 1'b0;
            unique case (state_q)
                // Core requests win over debug readback.
                ST_IDLE: begin
                    if (req_c) begin
                        wr_q <= (cpu_mmrw_i == MM_WR);
                        if (cpu_adrs_i == IO_ADDR) begin
                            state_q <= ST_IO;
                        end else begin
                            state_q     <= ST_MEM;
                            mem_adrs_q  <= cpu_adrs_i;
                            mem_wdata_q <= cpu_wdata_i;
                            mem_wr_en_q <= (cpu_mmrw_i == MM_WR);
                            mem_rd_en_q <= (cpu_mmrw_i == MM_RD);
                        end
                    end else if (endseq_i) begin
                        state_q     <= ST_DBG;
                        mem_adrs_q  <= resad_i;
                        mem_rd_en_q <= 1'b1;
                    end
                end
                ST_MEM: begin
                    if (mem_ready_i) begin
                        mem_wr_en_q <= 1'b0;
                        mem_rd_en_q <= 1'b0;
                        if (!wr_q) begin
                            cpu_rdata_q <= mem_rdata_i;
                        end
                        cpu_done_q <= 1'b1;
                        state_q    <= ST_DONE;
                    end else if (tc_c) begin
                        mem_wr_en_q <= 1'b0;
                        mem_rd_en_q <= 1'b0;
                        bus_err_q   <= 1'b1;
                        cpu_rdata_q <= '1;
                        cpu_done_q  <= 1'b1;
                        state_q     <= ST_DONE;
                    end
                end
                // Core holds its operands while stalled, so they are used directly here.
                ST_IO: begin
                    if (wr_q) begin
                        io_out_q <= cpu_wdata_i;
                    end else begin
                        cpu_rdata_q <= io_in_i;
                    end
                    cpu_done_q <= 1'b1;
                    state_q    <= ST_DONE;
                end
                ST_DBG: begin
                    if (mem_ready_i) begin
                        mem_rd_en_q <= 1'b0;
                        resdt_q     <= mem_rdata_i;
                        state_q     <= ST_IDLE;
                    end else if (tc_c) begin
                        mem_rd_en_q <= 1'b0;
                        bus_err_q   <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Stall must already be high in the cycle a request appears, and drop with reset.
    assign cpu_stall_c_o = !reset_i &&
                           (((state_q == ST_IDLE) && req_c) ||
                            (state_q == ST_MEM) || (state_q == ST_IO) || (state_q == ST_DBG));

    assign cpu_rdata_o = cpu_rdata_q;
    assign cpu_done_o  = cpu_done_q;
    assign bus_err_o   = bus_err_q;
    assign mem_adrs_o  = mem_adrs_q;
    assign mem_wdata_o = mem_wdata_q;
    assign mem_wr_en_o = mem_wr_en_q;
    assign mem_rd_en_o = mem_rd_en_q;
    assign io_out_o    = io_out_q;
    assign resdt_o     = resdt_q;

endmodule

// File: tb/tb_cdec_bus_ctrl.sv
// Scoreboard bench for cdec_bus_ctrl: randomized core traffic against a behavioural memory/IO model,
// plus directed latency, timeout, debug-readback and reset scenarios.
module tb_cdec_bus_ctrl;
    import cdec_bus_ctrl_pkg::*;

    localparam logic [7:0] IO_A = 8'hFF;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] cpu_mmrw = 2'b00;
    logic [7:0] cpu_adrs = '0;
    logic [7:0] cpu_wdata = '0;
    logic [7:0] cpu_rdata;
    logic       cpu_stall;
    logic       cpu_done;
    logic       bus_err;
    logic [7:0] mem_adrs;
    logic [7:0] mem_wdata;
    logic       mem_wr_en;
    logic       mem_rd_en;
    logic [7:0] mem_rdata = '0;
    logic       mem_ready = 1'b0;
    logic [7:0] io_in = '0;
    logic [7:0] io_out;
    logic       endseq = 1'b0;
    logic [7:0] resad = '0;
    logic [7:0] resdt;

    cdec_bus_ctrl #(
        .DW(8), .AW(8), .IO_ADDR(8'hFF), .TMO(15)
    ) dut (
        .clock_i       (clk),
        .reset_i       (rst),
        .cpu_mmrw_i    (cpu_mmrw),
        .cpu_adrs_i    (cpu_adrs),
        .cpu_wdata_i   (cpu_wdata),
        .cpu_rdata_o   (cpu_rdata),
        .cpu_stall_c_o (cpu_stall),
        .cpu_done_o    (cpu_done),
        .bus_err_o     (bus_err),
        .mem_adrs_o    (mem_adrs),
        .mem_wdata_o   (mem_wdata),
        .mem_wr_en_o   (mem_wr_en),
        .mem_rd_en_o   (mem_rd_en),
        .mem_rdata_i   (mem_rdata),
        .mem_ready_i   (mem_ready),
        .io_in_i       (io_in),
        .io_out_o      (io_out),
        .endseq_i      (endseq),
        .resad_i       (resad),
        .resdt_o       (resdt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         chk_rd;
        logic [7:0] rd;
        bit         chk_io;
        logic [7:0] io;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] mem     [256];
    logic [7:0] ref_mem [256];
    logic [7:0] io_ref = '0;
    int         mem_mode = 0;
    int         fix_wait = 0;
    int         n_checks = 0;
    int         n_fail = 0;

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Memory model: mode 0 random 0..3 wait cycles, 1 fixed wait, 2 never ready.
    initial begin : responder
        int cnt;
        int tgt;
        cnt = 0;
        tgt = 0;
        forever begin
            @(negedge clk);
            if (mem_wr_en || mem_rd_en) begin
                if (cnt >= tgt) begin
                    mem_ready = 1'b1;
                    mem_rdata = mem[mem_adrs];
                    if (mem_wr_en) mem[mem_adrs] = mem_wdata;
                end else begin
                    mem_ready = 1'b0;
                    mem_rdata = 8'($urandom);
                    cnt++;
                end
            end else begin
                cnt = 0;
                mem_ready = (mem_mode == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
                mem_rdata = 8'($urandom);
                tgt = (mem_mode == 0) ? int'($urandom_range(0, 3)) :
                      (mem_mode == 1) ? fix_wait : 1000000;
            end
        end
    end

    // Monitor: pops one expectation per completed access and checks the bus rules.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (mem_wr_en || mem_rd_en) begin
                    check_int("strobe_exclusive", int'(mem_wr_en && mem_rd_en), 0);
                    check_int("io_addr_on_bus", int'(mem_adrs == IO_A), 0);
                end
                if (cpu_done) begin
                    if (exp_q.size() == 0) begin
                        check_int("unexpected_done", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        if (e.chk_rd) check8("sb_rdata", cpu_rdata, e.rd);
                        if (e.chk_io) check8("sb_io_out", io_out, e.io);
                        check_int("sb_done_stall", int'(cpu_stall), 0);
                    end
                end
            end
        end
    end

    // Issues one core access at the current negedge and waits (bounded) for cpu_done.
    task automatic access(input logic [1:0] op, input logic [7:0] a, input logic [7:0] wd,
                          output int ncyc, output int nstall, output int nstb);
        exp_t e;
        bit   done;
        e.chk_rd = 1'b0; e.rd = '0; e.chk_io = 1'b0; e.io = '0;
        cpu_mmrw = op; cpu_adrs = a; cpu_wdata = wd;
        if (a == IO_A) begin
            if (op == MM_WR) io_ref = wd;
            else begin e.chk_rd = 1'b1; e.rd = io_in; end
            e.chk_io = 1'b1; e.io = io_ref;
        end else if (op == MM_WR) begin
            ref_mem[a] = wd;
        end else begin
            e.chk_rd = 1'b1;
            e.rd = (mem_mode == 2) ? 8'hFF : ref_mem[a];
        end
        exp_q.push_back(e);
        #1;
        nstall = int'(cpu_stall);
        nstb = 0;
        ncyc = 0;
        done = 1'b0;
        for (int k = 2; k <= 40 && !done; k++) begin
            @(negedge clk);
            if (mem_wr_en || mem_rd_en) nstb++;
            if (cpu_stall) nstall++;
            if (cpu_done) begin done = 1'b1; ncyc = k; end
        end
        if (!done) check_int("access_done_timeout", 0, 1);
        cpu_mmrw = MM_IDLE;
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int c, s, b, act;
        for (int i = 0; i < 256; i++) begin
            mem[i] = 8'($urandom);
            ref_mem[i] = mem[i];
        end
        repeat (3) @(negedge clk);
        check8("rst_cpu_rdata", cpu_rdata, 8'h00);
        check8("rst_io_out", io_out, 8'h00);
        check8("rst_resdt", resdt, 8'h00);
        check8("rst_mem_adrs", mem_adrs, 8'h00);
        check8("rst_mem_wdata", mem_wdata, 8'h00);
        check_int("rst_ctrl_bits", int'({mem_wr_en, mem_rd_en, cpu_stall, cpu_done, bus_err}), 0);
        rst = 1'b0;

        // Write, ready in the strobe's own cycle.
        mem_mode = 1; fix_wait = 0;
        @(negedge clk);
        access(MM_WR, 8'h10, 8'hA5, c, s, b);
        check_int("t1_done_cycle", c, 3);
        check_int("t1_wr_strobe_cycles", b, 1);
        check_int("t1_stall_cycles", s, 2);

        // Read with four wait cycles.
        fix_wait = 4;
        mem[8'h20] = 8'h3C; ref_mem[8'h20] = 8'h3C;
        @(negedge clk);
        access(MM_RD, 8'h20, 8'h00, c, s, b);
        check_int("t2_stall_cycles", s, 6);
        check_int("t2_done_cycle", c, 7);
        check8("t2_rdata", cpu_rdata, 8'h3C);

        // IO register write then read.
        mem_mode = 0;
        @(negedge clk);
        io_in = 8'h5A;
        access(MM_WR, IO_A, 8'h81, c, s, b);
        check_int("t3_wr_no_strobe", b, 0);
        check8("t3_io_out", io_out, 8'h81);
        access(MM_RD, IO_A, 8'h00, c, s, b);
        check_int("t3_rd_no_strobe", b, 0);
        check8("t3_io_rdata", cpu_rdata, 8'h5A);

        // Randomized traffic, often back-to-back.
        for (int i = 0; i < 80; i++) begin
            logic [1:0] op;
            logic [7:0] a;
            op = ($urandom_range(0, 1) == 0) ? MM_WR : MM_RD;
            a = ($urandom_range(0, 7) == 0) ? IO_A : 8'($urandom_range(0, 15));
            io_in = 8'($urandom);
            access(op, a, 8'($urandom), c, s, b);
            if (a == IO_A) check_int("rnd_io_no_strobe", b, 0);
            else check_int("rnd_mem_strobe", int'(b >= 1), 1);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end

        // Debug readback after halt, with a core request arriving mid-readback.
        access(MM_WR, 8'h07, 8'hC3, c, s, b);
        access(MM_WR, 8'h08, 8'h96, c, s, b);
        endseq = 1'b1; resad = 8'h07;
        act = 0;
        for (int k = 0; k < 10 && act == 0; k++) begin
            @(negedge clk);
            act = int'(mem_rd_en);
        end
        check_int("t5_dbg_strobe", act, 1);
        check8("t5_dbg_adrs", mem_adrs, 8'h07);
        access(MM_RD, 8'h10, 8'h00, c, s, b);
        check_int("t5_req_after_dbg", int'(c >= 4), 1);
        check8("t5_resdt", resdt, 8'hC3);
        resad = 8'h08;
        for (int k = 0; k < 20 && resdt != 8'h96; k++) @(negedge clk);
        check8("t5_resad_track", resdt, 8'h96);
        endseq = 1'b0;
        repeat (8) @(negedge clk);
        check_int("t5_dbg_exit", int'(mem_rd_en), 0);

        // Timeout: strobe held TMO cycles, all-ones data, sticky error.
        mem_mode = 2;
        @(negedge clk);
        check_int("t4_err_before", int'(bus_err), 0);
        access(MM_RD, 8'h05, 8'h00, c, s, b);
        check_int("t4_strobe_cycles", b, 15);
        check_int("t4_done_cycle", c, 17);
        check_int("t4_bus_err", int'(bus_err), 1);
        mem_mode = 0;
        @(negedge clk);
        access(MM_RD, 8'h05, 8'h00, c, s, b);
        check_int("t4_err_sticky", int'(bus_err), 1);

        // Reset in the middle of a memory wait, then reserved code.
        mem_mode = 2;
        @(negedge clk);
        cpu_mmrw = MM_RD; cpu_adrs = 8'h30;
        repeat (4) @(negedge clk);
        check_int("t6_strobe_before", int'(mem_rd_en), 1);
        #2 rst = 1'b1;
        #1;
        check_int("t6_async_drop", int'({mem_wr_en, mem_rd_en, cpu_stall}), 0);
        cpu_mmrw = MM_IDLE;
        @(negedge clk);
        rst = 1'b0;
        mem_mode = 0;
        @(negedge clk);
        check_int("t6_idle_after", int'({mem_wr_en, mem_rd_en, cpu_stall, cpu_done, bus_err}), 0);
        check8("t6_rdata_cleared", cpu_rdata, 8'h00);
        act = 0;
        cpu_mmrw = MM_RSVD;
        for (int k = 0; k < 10; k++) begin
            cpu_adrs = 8'($urandom);
            #1;
            act += int'(mem_wr_en || mem_rd_en || cpu_stall || cpu_done || bus_err);
            @(negedge clk);
        end
        cpu_mmrw = MM_IDLE;
        check_int("t6_rsvd_no_activity", act, 0);
        check_int("scoreboard_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
